// File: rtl/uart_tx_fifo.sv
// Byte-wide circular transmit FIFO that drains into uart_tx through its
// START/BUSY/DATA handshake, with overflow detection and an acknowledge timeout.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [7:0]            WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  OVERFLOW,
  output logic                  TX_START,
  output logic [7:0]            TX_DATA,
  input  logic                  TX_BUSY
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [CNT_W-1:0]      ack_cnt;
  logic                  wr_accept;
  logic                  pop;

  assign LEVEL = level;
  assign EMPTY = (level == '0);
  assign FULL  = (level == (DEPTH_LOG2 + 1)'(DEPTH));

  // FULL is the registered occupancy; a same-cycle pop never rescues a write.
  assign wr_accept = WR_EN && !FULL;
  assign pop       = (state == IDLE) && !EMPTY && !TX_BUSY;

  // NOTE: storage has no reset; pointers and LEVEL alone define what is valid,
  // and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (wr_accept) begin
      mem[wr_ptr] <= WR_DATA;
    end
  end

  // NOTE: every register is updated with <= so all blocks see pre-edge values
  // regardless of evaluation order.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      if (WR_EN && FULL) begin
        OVERFLOW <= 1'b1;
      end
      case ({wr_accept, pop})
        2'b10:   level <= level + (DEPTH_LOG2 + 1)'(1);
        2'b01:   level <= level - (DEPTH_LOG2 + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      TX_START <= 1'b0;
      TX_DATA  <= 8'h00;
      ack_cnt  <= '0;
    end else begin
      TX_START <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            TX_DATA  <= mem[rd_ptr];
            TX_START <= 1'b1;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          ack_cnt <= '0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // Counting 0..ACK_TIMEOUT-1 gives exactly ACK_TIMEOUT cycles here.
          if (TX_BUSY) begin
            state <= WAIT_DONE;
          end else if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            state <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!TX_BUSY) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a small uart_tx BUSY model answers TX_START,
// and every launched byte is logged for order checks against hand-computed data.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;

  // BUSY model: rises one cycle after a START pulse, holds busy_hold cycles.
  logic       busy_auto = 1'b0;
  logic       busy_force = 1'b0;
  logic       busy_model = 1'b0;
  logic       busy_pending = 1'b0;
  int         busy_cnt = 0;
  int         busy_hold = 10;
  logic [7:0] log_q [$];
  logic       track = 1'b0;
  int         max_level = 0;

  assign tx_busy = busy_auto ? busy_model : busy_force;

  uart_tx_fifo #(.DEPTH_LOG2(4), .ACK_TIMEOUT(15)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .WR_DATA  (wr_data),
    .WR_EN    (wr_en),
    .FULL     (full),
    .EMPTY    (empty),
    .LEVEL    (level),
    .OVERFLOW (overflow),
    .TX_START (tx_start),
    .TX_DATA  (tx_data),
    .TX_BUSY  (tx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start) log_q.push_back(tx_data);
    if (track && int'(level) > max_level) max_level = int'(level);
    if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) busy_model = 1'b0;
    end
    if (busy_pending) begin
      busy_pending = 1'b0;
      busy_model   = 1'b1;
      busy_cnt     = busy_hold;
    end
    if (tx_start && busy_auto) busy_pending = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (log_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    check("start_count", 32'(log_q.size()), 32'(target));
  endtask

  initial begin
    int base;

    // Reset state, sampled while reset is still applied.
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    rst_n = 1'b1;
    tick();

    // Single byte: START two cycles after the write, exactly once.
    busy_auto = 1'b1;
    busy_hold = 10;
    write_byte(8'h41);
    check("single_level1", 32'(level), 32'd1);
    check("single_empty0", 32'(empty), 32'd0);
    check("single_nostart_yet", 32'(tx_start), 32'd0);
    tick();
    check("single_start", 32'(tx_start), 32'd1);
    check("single_data", 32'(tx_data), 32'h41);
    check("single_level0", 32'(level), 32'd0);
    tick();
    check("single_start_drop", 32'(tx_start), 32'd0);
    check("single_data_hold", 32'(tx_data), 32'h41);
    repeat (20) tick();
    check("single_count", 32'(log_q.size()), 32'd1);
    check("single_logged", 32'(log_q[0]), 32'h41);
    check("single_empty_end", 32'(empty), 32'd1);

    // Burst fill with BUSY held high, then overflow, then ordered drain.
    busy_auto  = 1'b0;
    busy_force = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'h30 + 8'(i));
    check("burst_level16", 32'(level), 32'd16);
    check("burst_full", 32'(full), 32'd1);
    check("burst_no_ovf", 32'(overflow), 32'd0);
    write_byte(8'h99);
    check("burst_drop_level", 32'(level), 32'd16);
    check("burst_overflow", 32'(overflow), 32'd1);
    base      = log_q.size();
    busy_hold = 3;
    busy_auto = 1'b1;
    wait_starts(base + 16, 400);
    repeat (15) tick();
    check("burst_total", 32'(log_q.size()), 32'(base + 16));
    for (int i = 0; i < 16; i++) check("burst_order", 32'(log_q[base+i]), 32'h30 + 32'(i));
    check("burst_empty_end", 32'(empty), 32'd1);
    check("burst_ovf_sticky", 32'(overflow), 32'd1);

    // Wrap-around: 40 bytes in groups of 5 from a fresh reset.
    do_reset();
    check("wrap_ovf_cleared", 32'(overflow), 32'd0);
    base      = log_q.size();
    max_level = 0;
    track     = 1'b1;
    for (int g = 0; g < 8; g++) begin
      busy_auto  = 1'b0;
      busy_force = 1'b1;
      for (int k = 0; k < 5; k++) write_byte(8'h50 + 8'(g * 5 + k));
      busy_auto = 1'b1;
      wait_starts(base + 5 * (g + 1), 100);
      repeat (12) tick();
    end
    track = 1'b0;
    check("wrap_max_level", 32'(max_level), 32'd5);
    for (int i = 0; i < 40; i++) check("wrap_order", 32'(log_q[base+i]), 32'h50 + 32'(i));

    // Ack timeout: BUSY never rises; AA gives up after 15 WAIT_ACK cycles.
    do_reset();
    busy_auto  = 1'b0;
    busy_force = 1'b0;
    base       = log_q.size();
    write_byte(8'hAA);
    write_byte(8'hBB);
    check("tmo_start_aa", 32'(tx_start), 32'd1);
    check("tmo_data_aa", 32'(tx_data), 32'hAA);
    check("tmo_level1", 32'(level), 32'd1);
    repeat (16) tick();
    check("tmo_still_waiting", 32'(tx_start), 32'd0);
    check("tmo_one_start", 32'(log_q.size()), 32'(base + 1));
    check("tmo_level_held", 32'(level), 32'd1);
    tick();
    check("tmo_start_bb", 32'(tx_start), 32'd1);
    check("tmo_data_bb", 32'(tx_data), 32'hBB);
    check("tmo_level0", 32'(level), 32'd0);
    repeat (20) tick();
    check("tmo_two_starts", 32'(log_q.size()), 32'(base + 2));

    // Reset during WAIT_DONE while uart_tx keeps BUSY high.
    busy_hold = 20;
    busy_auto = 1'b1;
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    repeat (3) tick();
    check("rmid_level_before", 32'(level), 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rmid_level", 32'(level), 32'd0);
    check("rmid_empty", 32'(empty), 32'd1);
    check("rmid_overflow", 32'(overflow), 32'd0);
    check("rmid_tx_start", 32'(tx_start), 32'd0);
    check("rmid_tx_data", 32'(tx_data), 32'h00);
    base = log_q.size();
    write_byte(8'hC3);
    repeat (5) tick();
    check("rmid_busy_block", 32'(log_q.size()), 32'(base));
    check("rmid_level_queued", 32'(level), 32'd1);
    wait_starts(base + 1, 60);
    check("rmid_late_data", 32'(log_q[base]), 32'hC3);
    repeat (30) tick();

    // Write in the same cycle as the IDLE pop with three bytes queued.
    busy_hold  = 3;
    busy_auto  = 1'b0;
    busy_force = 1'b1;
    write_byte(8'hD0);
    write_byte(8'hD1);
    write_byte(8'hD2);
    check("simul_level3", 32'(level), 32'd3);
    base      = log_q.size();
    busy_auto = 1'b1;
    write_byte(8'hD3);
    check("simul_level_same", 32'(level), 32'd3);
    check("simul_start", 32'(tx_start), 32'd1);
    check("simul_data", 32'(tx_data), 32'hD0);
    wait_starts(base + 4, 100);
    repeat (12) tick();
    for (int i = 0; i < 4; i++) check("simul_order", 32'(log_q[base+i]), 32'hD0 + 32'(i));
    check("simul_empty_end", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
